dram_user_master: RTL and testbench
===================================

// Module: dram_user_master
// PURPOSE
//  Initiator for the dram_controller user port (u_*). It buffers host requests in a small FIFO
//  and issues them one at a time, following the busy/ack/valid handshake. Read data is returned
//  to the host as a one-cycle response pulse. It sits between host logic and dram_controller and
//  is the driving end of the interface that dram_controller responds on.
// PARAMETERS
//  NUMBER_OF_COLUMNS  8    columns per row (bits)
//  NUMBER_OF_ROWS     128  rows per bank
//  NUMBER_OF_BANKS    8    banks
//  U_DATA_WIDTH       2    user data width
//  DRAM_DATA_WIDTH    2    dram data width; COLUMN_WIDTH=$clog2(NUMBER_OF_COLUMNS/DRAM_DATA_WIDTH)
//  FIFO_DEPTH         4    request FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES     256  maximum cycles waited for u_cmd_ack or u_data_valid
//  (derived) U_ADDR_WIDTH = clog2(BANKS)+clog2(ROWS)+COLUMN_WIDTH = 12; format {bank,row,col}
// PORTS
//  u_clk         in   1             clock; all logic is on the rising edge
//  u_rst_n       in   1             synchronous reset, active low
//  req_valid     in   1             host request valid
//  req_ready     out  1             FIFO can accept (= !full && u_rst_n)
//  req_cmd       in   1             1=write, 0=read
//  req_addr      in   U_ADDR_WIDTH  request address {bank,row,col}
//  req_wdata     in   U_DATA_WIDTH  write data
//  rsp_valid     out  1             one-cycle pulse: read data ready, or timeout
//  rsp_data      out  U_DATA_WIDTH  read data (0 on timeout)
//  rsp_err       out  1             qualifies rsp_valid: the transaction timed out
//  m_idle        out  1             FIFO empty and FSM in IDLE
//  u_en          out  1             controller enable; high only while a command is being issued
//  u_addr        out  U_ADDR_WIDTH  command address
//  u_data_i      out  U_DATA_WIDTH  write data
//  u_cmd         out  1             1=write, 0=read
//  u_data_o      in   U_DATA_WIDTH  read data from controller
//  u_data_valid  in   1             read data valid
//  u_cmd_ack     in   1             command accepted
//  u_busy        in   1             controller busy (includes refresh)
// BEHAVIOUR
//  Reset (u_rst_n=0 at an edge): FIFO flushed, FSM->IDLE, timer=0. All u_* outputs, rsp_*, and
//   rsp_data go to 0; m_idle=1. Reset mid-transaction abandons it: no response is emitted.
//  Push on req_valid&&req_ready; the entry is visible at the FIFO head the next cycle.
//   Push and pop in the same cycle are allowed when full. A push while !req_ready is ignored.
//  FSM (registered outputs):
//   IDLE:      if !empty && !u_busy -> load head into u_addr/u_cmd/u_data_i, set u_en=1 -> ISSUE.
//   ISSUE:     hold u_* stable. On u_cmd_ack: pop FIFO, u_en<=0, then
//              write -> WAIT_FREE; read -> WAIT_DATA.
//   WAIT_FREE: wait for u_busy==0 -> IDLE.
//   WAIT_DATA: on u_data_valid (u_busy==0): rsp_data<=u_data_o, rsp_valid<=1 for one cycle -> IDLE.
//  Latency: a push in cycle N drives u_en=1 at N+2 at the earliest, given u_busy=0.
//   Read data appears on rsp_valid 1 cycle after u_data_valid.
//  Timeout: timer clears on entry to ISSUE/WAIT_DATA and increments each cycle in those states.
//   At timer==TIMEOUT_CYCLES-1 without the awaited event:
//   rsp_valid=1, rsp_err=1, rsp_data=0; pop the head if in ISSUE; u_en<=0 -> IDLE.
//  Simultaneous events: u_cmd_ack in the same cycle as the timeout -> the ack wins, no error.
//   u_busy rising while in IDLE blocks the issue.
//  Only one command is outstanding at a time; u_addr/u_cmd/u_data_i change only on entry to ISSUE.
//  FIFO pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
//   full  = MSBs differ and the rest are equal; empty = pointers equal.
// STRUCTURE
//  Package dram_pkg: geometry localparams and derived widths (COLUMN_WIDTH, ROW_WIDTH,
//   BANK_ID_WIDTH, U_ADDR_WIDTH); FSM state encoding; CMD_READ=0 / CMD_WRITE=1.
//  Sub-module dram_req_fifo: synchronous FIFO, width 1+U_ADDR_WIDTH+U_DATA_WIDTH, depth FIFO_DEPTH,
//   ports push/pop/full/empty/head. The FSM, timer and response registers stay in the top.
// TESTING (bench: dram_user_master + dram_controller + dram; u_clk period 10us)
//  1 Reset: hold u_rst_n=0 3 cycles with req_valid=1 -> all outputs 0, m_idle=1, no push.
//  2 Write 2'b10 to addr 12'h5A3, then read 12'h5A3 -> one u_cmd_ack per command; rsp_valid once,
//    rsp_data=2'b10, rsp_err=0.
//  3 Push 5 requests back-to-back with FIFO_DEPTH=4 -> req_ready=0 after 4 accepted; all 5 execute
//    in order; u_en never high while u_busy=1 before issue.
//  4 Stub the controller and never assert u_cmd_ack -> after 256 cycles: rsp_valid=1, rsp_err=1,
//    entry dropped, FSM in IDLE.
//  5 Read issued during a refresh (u_busy held high) -> u_en stays 0 until u_busy=0; data correct.
//  6 Assert u_rst_n=0 while in WAIT_DATA -> no rsp_valid; FIFO empty; next read completes correctly.

Source files
------------

// File: rtl/dram_pkg.sv
// dram_pkg: geometry, derived widths, command codes and master FSM states for the dram user port
package dram_pkg;
  localparam int NUMBER_OF_COLUMNS = 8;
  localparam int NUMBER_OF_ROWS = 128;
  localparam int NUMBER_OF_BANKS = 8;
  localparam int U_DATA_WIDTH = 2;
  localparam int DRAM_DATA_WIDTH = 2;
  localparam int COLUMN_WIDTH = $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH);
  localparam int ROW_WIDTH = $clog2(NUMBER_OF_ROWS);
  localparam int BANK_ID_WIDTH = $clog2(NUMBER_OF_BANKS);
  localparam int U_ADDR_WIDTH = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
  localparam int REQ_WIDTH = 1 + U_ADDR_WIDTH + U_DATA_WIDTH;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FREE, WAIT_DATA} state_t;
endpackage

// File: rtl/dram_req_fifo.sv
// dram_req_fifo: synchronous request FIFO with extra-MSB pointers for full/empty detection
module dram_req_fifo
  import dram_pkg::*;
#(
  parameter int WIDTH = REQ_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             u_clk,
  input  logic             u_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge u_clk) begin
    if (!u_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/dram_user_master.sv
// dram_user_master: queues host requests and issues them one at a time on the dram_controller user port
module dram_user_master
  import dram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    u_clk,
  input  logic                    u_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_cmd,
  input  logic [U_ADDR_WIDTH-1:0] req_addr,
  input  logic [U_DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [U_DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    m_idle,
  output logic                    u_en,
  output logic [U_ADDR_WIDTH-1:0] u_addr,
  output logic [U_DATA_WIDTH-1:0] u_data_i,
  output logic                    u_cmd,
  input  logic [U_DATA_WIDTH-1:0] u_data_o,
  input  logic                    u_data_valid,
  input  logic                    u_cmd_ack,
  input  logic                    u_busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state;
  logic [TW-1:0] timer;
  logic full, empty, push, pop, timeout;
  logic [REQ_WIDTH-1:0] head;
  assign req_ready = !full && u_rst_n;
  assign push = req_valid && req_ready;
  assign timeout = timer == TW'(TIMEOUT_CYCLES - 1);
  assign pop = (state == ISSUE) && (u_cmd_ack || timeout);
  assign m_idle = empty && (state == IDLE);
  dram_req_fifo #(.WIDTH(REQ_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .u_clk  (u_clk),
    .u_rst_n(u_rst_n),
    .push   (push),
    .pop    (pop),
    .din    ({req_cmd, req_addr, req_wdata}),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );
  always_ff @(posedge u_clk) begin
    if (!u_rst_n) begin
      state <= IDLE;
      timer <= '0;
      u_en <= 1'b0;
      u_addr <= '0;
      u_data_i <= '0;
      u_cmd <= CMD_READ;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      case (state)
        IDLE: if (!empty && !u_busy) begin
          {u_cmd, u_addr, u_data_i} <= head;
          u_en <= 1'b1;
          timer <= '0;
          state <= ISSUE;
        end
        ISSUE: if (u_cmd_ack) begin
          u_en <= 1'b0;
          timer <= '0;
          state <= (u_cmd == CMD_WRITE) ? WAIT_FREE : WAIT_DATA;
        end else if (timeout) begin
          u_en <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
          rsp_data <= '0;
          state <= IDLE;
        end else timer <= timer + 1'b1;
        WAIT_FREE: if (!u_busy) state <= IDLE;
        WAIT_DATA: if (u_data_valid) begin
          rsp_data <= u_data_o;
          rsp_valid <= 1'b1;
          state <= IDLE;
        end else if (timeout) begin
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
          rsp_data <= '0;
          state <= IDLE;
        end else timer <= timer + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_user_master.sv
// tb_dram_user_master: directed stimulus against a behavioural controller, scoreboarded responses
module tb_dram_user_master;
  logic u_clk = 0, u_rst_n = 0;
  logic req_valid = 0, req_cmd = 0;
  logic [11:0] req_addr = 0;
  logic [1:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, m_idle, u_en, u_cmd;
  logic [1:0] rsp_data, u_data_i;
  logic [11:0] u_addr;
  logic [1:0] u_data_o;
  logic u_data_valid, u_cmd_ack, u_busy;

  int checks = 0, errors = 0;
  logic [2:0] sb [$];
  logic [11:0] exp_order [$], got_q [$];
  logic [1:0] mem [4096], ref_mem [4096];
  int mst = 0, lat = 3, ack_cnt = 0;
  logic refresh = 0, stub = 0;

  dram_user_master dut (
    .u_clk(u_clk), .u_rst_n(u_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .m_idle(m_idle), .u_en(u_en), .u_addr(u_addr),
    .u_data_i(u_data_i), .u_cmd(u_cmd), .u_data_o(u_data_o), .u_data_valid(u_data_valid),
    .u_cmd_ack(u_cmd_ack), .u_busy(u_busy)
  );

  always #5us u_clk = ~u_clk;

  initial begin
    #500ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Behavioural controller: acks an enabled command, stays busy lat cycles, then returns read data.
  initial begin
    int cnt;
    logic m_cmd;
    logic [11:0] m_addr;
    u_busy = 0; u_cmd_ack = 0; u_data_valid = 0; u_data_o = 0;
    cnt = 0; m_cmd = 0; m_addr = 0;
    for (int i = 0; i < 4096; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    forever begin
      @(posedge u_clk); #1ns;
      u_cmd_ack = 0; u_data_valid = 0;
      if (!u_rst_n) begin
        mst = 0; u_busy = 0;
      end else if (mst == 0) begin
        if (refresh) u_busy = 1;
        else if (u_en && !stub) begin
          u_cmd_ack = 1; u_busy = 1; cnt = lat; m_cmd = u_cmd; m_addr = u_addr;
          if (u_cmd) mem[u_addr] = u_data_i;
          got_q.push_back(u_addr);
          ack_cnt++;
          mst = 1;
        end else u_busy = 0;
      end else begin
        cnt--;
        if (cnt <= 0) begin
          u_busy = 0; mst = 0;
          if (!m_cmd) begin u_data_valid = 1; u_data_o = mem[m_addr]; end
        end
      end
    end
  end

  // Response monitor plus guard that an issue never starts while the controller was busy.
  initial begin
    logic en_prev, busy_prev;
    logic [2:0] e;
    en_prev = 0; busy_prev = 0;
    forever begin
      @(negedge u_clk);
      if (u_rst_n === 1'b1 && rsp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp err=%b data=%b required none", rsp_err, rsp_data);
        end else begin
          e = sb.pop_front();
          if ({rsp_err, rsp_data} !== e) begin
            errors++;
            $display("FAIL rsp got err=%b data=%b required err=%b data=%b", rsp_err, rsp_data, e[2], e[1:0]);
          end
        end
      end
      if (u_en === 1'b1 && en_prev === 1'b0) begin
        checks++;
        if (busy_prev !== 1'b0) begin
          errors++;
          $display("FAIL issue_while_busy busy=%b required 0", busy_prev);
        end
      end
      en_prev = u_en; busy_prev = u_busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic cmd, input logic [11:0] addr, input logic [1:0] d);
    int n = 0;
    @(negedge u_clk);
    req_valid = 1; req_cmd = cmd; req_addr = addr; req_wdata = d;
    while (!req_ready && n < 1000) begin @(negedge u_clk); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL push_timeout ready=%b required 1", req_ready);
    end else begin
      if (stub) sb.push_back(3'b100);
      else begin
        if (cmd) ref_mem[addr] = d; else sb.push_back({1'b0, ref_mem[addr]});
        exp_order.push_back(addr);
      end
    end
    @(posedge u_clk); #1ns;
    req_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(negedge u_clk);
    while (!(m_idle && mst == 0 && sb.size() == 0) && n < 2000) begin @(negedge u_clk); n++; end
    chk({name, "_idle"}, {31'd0, m_idle && sb.size() == 0}, 1);
  endtask

  task automatic check_order(input string name);
    logic [11:0] g;
    while (exp_order.size() > 0) begin
      if (got_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_order missing addr %h", name, exp_order[0]);
        void'(exp_order.pop_front());
      end else begin
        g = got_q.pop_front();
        chk({name, "_order"}, {20'd0, g}, {20'd0, exp_order.pop_front()});
      end
    end
    chk({name, "_extra_cmds"}, got_q.size(), 0);
  endtask

  initial begin
    int a0, n;
    req_valid = 1;
    repeat (3) @(posedge u_clk);
    @(negedge u_clk);
    chk("t1_u_en", {31'd0, u_en}, 0);
    chk("t1_u_addr", {20'd0, u_addr}, 0);
    chk("t1_u_data_i", {30'd0, u_data_i}, 0);
    chk("t1_u_cmd", {31'd0, u_cmd}, 0);
    chk("t1_rsp", {29'd0, rsp_valid, rsp_err, rsp_data[0] | rsp_data[1]}, 0);
    chk("t1_rsp_data", {30'd0, rsp_data}, 0);
    chk("t1_m_idle", {31'd0, m_idle}, 1);
    chk("t1_req_ready", {31'd0, req_ready}, 0);
    req_valid = 0;
    u_rst_n = 1;
    repeat (3) @(negedge u_clk);
    chk("t1_no_push", {31'd0, m_idle}, 1);
    chk("t1_ready_after", {31'd0, req_ready}, 1);
    chk("t1_no_issue", {31'd0, u_en}, 0);

    a0 = ack_cnt;
    push(1, 12'h5A3, 2'b10);
    push(0, 12'h5A3, 2'b00);
    wait_idle("t2");
    chk("t2_acks", ack_cnt - a0, 2);
    check_order("t2");

    a0 = ack_cnt;
    refresh = 1;
    push(1, 12'h101, 2'b01);
    push(1, 12'h202, 2'b11);
    push(0, 12'h101, 2'b00);
    push(1, 12'h101, 2'b10);
    @(negedge u_clk);
    chk("t3_full_ready", {31'd0, req_ready}, 0);
    chk("t3_no_issue_busy", {31'd0, u_en}, 0);
    refresh = 0;
    push(0, 12'h101, 2'b00);
    wait_idle("t3");
    chk("t3_acks", ack_cnt - a0, 5);
    check_order("t3");

    stub = 1;
    push(0, 12'h0F0, 2'b00);
    n = 0;
    while (!u_en && n < 50) begin @(negedge u_clk); n++; end
    chk("t4_issued", {31'd0, u_en}, 1);
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge u_clk); n++; end
    chk("t4_latency", n, 256);
    chk("t4_en_dropped", {31'd0, u_en}, 0);
    wait_idle("t4");
    stub = 0;
    check_order("t4");

    refresh = 1;
    push(0, 12'h5A3, 2'b00);
    repeat (10) @(negedge u_clk);
    chk("t5_held", {31'd0, u_en}, 0);
    chk("t5_pending", {31'd0, m_idle}, 0);
    refresh = 0;
    wait_idle("t5");
    check_order("t5");

    lat = 30;
    push(0, 12'h202, 2'b00);
    n = 0;
    while (!u_cmd_ack && n < 50) begin @(negedge u_clk); n++; end
    chk("t6_acked", {31'd0, u_cmd_ack}, 1);
    repeat (3) @(negedge u_clk);
    u_rst_n = 0;
    repeat (2) @(negedge u_clk);
    sb.delete();
    u_rst_n = 1;
    repeat (40) @(negedge u_clk);
    chk("t6_m_idle", {31'd0, m_idle}, 1);
    lat = 3;
    push(0, 12'h202, 2'b00);
    wait_idle("t6");
    check_order("t6");

    chk("end_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
